unidade_load_store: RTL and testbench

//  Load/store unit between the MEM stage of the pipeline and the word-wide data memory
//  (combinational read, write on posedge). Converts byte addresses to word indices.

---
 rtl/unidade_load_store_if.sv | 33 +++
 rtl/unidade_load_store.sv | 162 ++++++++++++++++
 tb/tb_unidade_load_store.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/unidade_load_store_if.sv
// Request/response handshake and data-memory bus of the load/store unit.
// slave = the unit itself; master = pipeline MEM stage plus the data memory.
interface unidade_load_store_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_store;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_endereco;
    logic [31:0] req_dado;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_dado;
    logic        resp_erro;
    logic [31:0] mem_endereco;
    logic        mem_memWrite;
    logic [31:0] mem_dado_Escrito;
    logic [31:0] mem_dado_Lido;

    modport slave (
        input  req_valid, req_store, req_size, req_signed, req_endereco, req_dado,
        input  resp_ready, mem_dado_Lido,
        output req_ready, resp_valid, resp_dado, resp_erro,
        output mem_endereco, mem_memWrite, mem_dado_Escrito
    );

    modport master (
        output req_valid, req_store, req_size, req_signed, req_endereco, req_dado,
        output resp_ready, mem_dado_Lido,
        input  req_ready, resp_valid, resp_dado, resp_erro,
        input  mem_endereco, mem_memWrite, mem_dado_Escrito
    );
endinterface

// File: rtl/unidade_load_store.sv
// Load/store unit: byte/half/word loads with extension, sub-word stores via
// read-modify-write, alignment/range checking. One request in flight.
module unidade_load_store #(
    parameter int MEM_SIZE = 150
) (
    input logic              clock,
    input logic              reset_n,
    unidade_load_store_if.slave bus
);
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LOAD  = 3'd1;
    localparam logic [2:0] ST_MERGE = 3'd2;
    localparam logic [2:0] ST_WRITE = 3'd3;
    localparam logic [2:0] ST_RESP  = 3'd4;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    logic [2:0]  state_q, state_d;
    logic [1:0]  size_q, size_d;
    logic        signed_q, signed_d;
    logic [1:0]  off_q, off_d;
    logic [15:0] dado_q, dado_d;          // only the low half is ever merged
    logic [31:0] endereco_q, endereco_d;  // word index driven to memory
    logic [31:0] merge_q, merge_d;        // word written during WRITE
    logic [31:0] resp_dado_q, resp_dado_d;
    logic        resp_erro_q, resp_erro_d;

    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic [31:0] ext;
    logic [31:0] merged;
    logic [31:0] word_idx;
    logic        req_err;

    // Classify the incoming request: misaligned, reserved size or out of range.
    always_comb begin
        word_idx = {2'b00, bus.req_endereco[31:2]};
        req_err  = (bus.req_size == SZ_RSVD)
                || (bus.req_size == SZ_HALF && bus.req_endereco[0])
                || (bus.req_size == SZ_WORD && bus.req_endereco[1:0] != 2'b00)
                || (word_idx >= 32'(MEM_SIZE));
    end

    // Lane extraction with sign/zero extension, and lane replacement for stores.
    always_comb begin
        case (off_q)
            2'd0:    lane_b = bus.mem_dado_Lido[7:0];
            2'd1:    lane_b = bus.mem_dado_Lido[15:8];
            2'd2:    lane_b = bus.mem_dado_Lido[23:16];
            default: lane_b = bus.mem_dado_Lido[31:24];
        endcase
        lane_h = off_q[1] ? bus.mem_dado_Lido[31:16] : bus.mem_dado_Lido[15:0];

        case (size_q)
            SZ_BYTE: ext = {{24{signed_q & lane_b[7]}}, lane_b};
            SZ_HALF: ext = {{16{signed_q & lane_h[15]}}, lane_h};
            SZ_WORD: ext = bus.mem_dado_Lido;
            default: ext = 32'd0;
        endcase

        merged = bus.mem_dado_Lido;
        if (size_q == SZ_BYTE) begin
            case (off_q)
                2'd0:    merged[7:0]   = dado_q[7:0];
                2'd1:    merged[15:8]  = dado_q[7:0];
                2'd2:    merged[23:16] = dado_q[7:0];
                default: merged[31:24] = dado_q[7:0];
            endcase
        end else if (off_q[1]) begin
            merged[31:16] = dado_q;
        end else begin
            merged[15:0] = dado_q;
        end
    end

    // Next-state and datapath register updates.
    always_comb begin
        state_d     = state_q;
        size_d      = size_q;
        signed_d    = signed_q;
        off_d       = off_q;
        dado_d      = dado_q;
        endereco_d  = endereco_q;
        merge_d     = merge_q;
        resp_dado_d = resp_dado_q;
        resp_erro_d = resp_erro_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    size_d      = bus.req_size;
                    signed_d    = bus.req_signed;
                    off_d       = bus.req_endereco[1:0];
                    dado_d      = bus.req_dado[15:0];
                    resp_dado_d = 32'd0;
                    resp_erro_d = 1'b0;
                    if (req_err) begin
                        // Memory address is left untouched so nothing out of range is driven.
                        resp_erro_d = 1'b1;
                        state_d     = ST_RESP;
                    end else begin
                        endereco_d = word_idx;
                        if (!bus.req_store) begin
                            state_d = ST_LOAD;
                        end else if (bus.req_size == SZ_WORD) begin
                            merge_d = bus.req_dado;
                            state_d = ST_WRITE;
                        end else begin
                            state_d = ST_MERGE;
                        end
                    end
                end
            end
            ST_LOAD: begin
                resp_dado_d = ext;
                state_d     = ST_RESP;
            end
            ST_MERGE: begin
                merge_d = merged;
                state_d = ST_WRITE;
            end
            ST_WRITE: state_d = ST_RESP;
            ST_RESP:  if (bus.resp_ready) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // State registers; async reset drops any pending request without a write.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            size_q      <= SZ_BYTE;
            signed_q    <= 1'b0;
            off_q       <= 2'd0;
            dado_q      <= 16'd0;
            endereco_q  <= 32'd0;
            merge_q     <= 32'd0;
            resp_dado_q <= 32'd0;
            resp_erro_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            size_q      <= size_d;
            signed_q    <= signed_d;
            off_q       <= off_d;
            dado_q      <= dado_d;
            endereco_q  <= endereco_d;
            merge_q     <= merge_d;
            resp_dado_q <= resp_dado_d;
            resp_erro_q <= resp_erro_d;
        end
    end

    assign bus.req_ready        = (state_q == ST_IDLE);
    assign bus.resp_valid       = (state_q == ST_RESP);
    assign bus.resp_dado        = resp_dado_q;
    assign bus.resp_erro        = resp_erro_q;
    assign bus.mem_endereco     = endereco_q;
    assign bus.mem_memWrite     = (state_q == ST_WRITE);
    assign bus.mem_dado_Escrito = merge_q;
endmodule

// File: tb/tb_unidade_load_store.sv
// Directed bench for unidade_load_store with a 150-word behavioural data memory.
module tb_unidade_load_store;
    logic clock;
    logic reset_n;
    int   checks = 0;
    int   errors = 0;

    logic [31:0] mem [0:149];
    int          lat, wr_cnt, wr_at;
    logic [31:0] wr_addr;

    unidade_load_store_if bus ();

    unidade_load_store #(.MEM_SIZE(150)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Combinational-read, posedge-write data memory.
    assign bus.mem_dado_Lido = (bus.mem_endereco < 32'd150) ? mem[bus.mem_endereco[7:0]] : 32'd0;
    always @(posedge clock) begin
        if (bus.mem_memWrite && bus.mem_endereco < 32'd150)
            mem[bus.mem_endereco[7:0]] = bus.mem_dado_Escrito;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Present a request for one cycle (cycle C); returns in cycle C+1.
    task automatic send(input logic st, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] d);
        bus.req_store    = st;
        bus.req_size     = sz;
        bus.req_signed   = sg;
        bus.req_endereco = a;
        bus.req_dado     = d;
        bus.req_valid    = 1'b1;
        step();
        bus.req_valid    = 1'b0;
    endtask

    // From cycle C+1, find the cycle offset of resp_valid and record writes.
    task automatic wait_resp();
        lat    = 0;
        wr_cnt = 0;
        wr_at  = 0;
        for (int k = 1; k <= 8; k++) begin
            if (bus.mem_memWrite) begin
                wr_cnt++;
                wr_at   = k;
                wr_addr = bus.mem_endereco;
            end
            if (bus.resp_valid) begin
                lat = k;
                break;
            end
            step();
        end
    endtask

    // Full transaction with resp_ready=1, checking latency and response.
    task automatic xact(input string tag, input logic st, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] d,
                        input int exp_lat, input logic [31:0] exp_dado, input logic exp_err);
        send(st, sz, sg, a, d);
        wait_resp();
        chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_dado"}, bus.resp_dado, exp_dado);
        chk({tag, "_erro"}, {31'd0, bus.resp_erro}, {31'd0, exp_err});
        step();
    endtask

    initial begin
        for (int i = 0; i < 150; i++) mem[i] = 32'h0;
        mem[5]   = 32'h8899AABB;
        mem[149] = 32'h11223344;
        reset_n          = 1'b0;
        bus.req_valid    = 1'b0;
        bus.req_store    = 1'b0;
        bus.req_size     = 2'b00;
        bus.req_signed   = 1'b0;
        bus.req_endereco = 32'h0;
        bus.req_dado     = 32'h0;
        bus.resp_ready   = 1'b1;

        // Reset state
        #3;
        chk("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
        chk("rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
        chk("rst_resp_dado", bus.resp_dado, 32'd0);
        chk("rst_resp_erro", {31'd0, bus.resp_erro}, 32'd0);
        chk("rst_memwrite", {31'd0, bus.mem_memWrite}, 32'd0);
        chk("rst_mem_end", bus.mem_endereco, 32'd0);
        chk("rst_mem_wdata", bus.mem_dado_Escrito, 32'd0);
        #9 reset_n = 1'b1;
        step();

        // T1/T2 loads
        xact("ldb_s15", 1'b0, 2'b00, 1'b1, 32'h15, 32'h0, 2, 32'hFFFFFFAA, 1'b0);
        xact("ldb_u17", 1'b0, 2'b00, 1'b0, 32'h17, 32'h0, 2, 32'h00000088, 1'b0);
        xact("ldh_u16", 1'b0, 2'b01, 1'b0, 32'h16, 32'h0, 2, 32'h00008899, 1'b0);
        xact("ldh_s14", 1'b0, 2'b01, 1'b1, 32'h14, 32'h0, 2, 32'hFFFFAABB, 1'b0);
        xact("ldw_14",  1'b0, 2'b10, 1'b0, 32'h14, 32'h0, 2, 32'h8899AABB, 1'b0);
        xact("ldb_u257", 1'b0, 2'b00, 1'b0, 32'h257, 32'h0, 2, 32'h00000011, 1'b0);

        // T3 half store via read-modify-write
        xact("sth_16", 1'b1, 2'b01, 1'b0, 32'h16, 32'h00001234, 3, 32'h0, 1'b0);
        chk("sth_16_wrcnt", 32'(wr_cnt), 32'd1);
        chk("sth_16_wrat", 32'(wr_at), 32'd2);
        chk("sth_16_wraddr", wr_addr, 32'd5);
        chk("sth_16_mem", mem[5], 32'h1234AABB);

        // Word store then byte store into the same word
        xact("stw_20", 1'b1, 2'b10, 1'b0, 32'h20, 32'hDEADBEEF, 2, 32'h0, 1'b0);
        chk("stw_20_wrat", 32'(wr_at), 32'd1);
        chk("stw_20_mem", mem[8], 32'hDEADBEEF);
        xact("stb_21", 1'b1, 2'b00, 1'b0, 32'h21, 32'hFFFFFF55, 3, 32'h0, 1'b0);
        chk("stb_21_mem", mem[8], 32'hDEAD55EF);

        // T4 errors
        xact("ldw_13", 1'b0, 2'b10, 1'b0, 32'h13, 32'h0, 1, 32'h0, 1'b1);
        chk("ldw_13_wrcnt", 32'(wr_cnt), 32'd0);
        xact("stb_258", 1'b1, 2'b00, 1'b0, 32'h258, 32'hAB, 1, 32'h0, 1'b1);
        chk("stb_258_wrcnt", 32'(wr_cnt), 32'd0);
        chk("stb_258_mem149", mem[149], 32'h11223344);
        xact("ldh_odd", 1'b0, 2'b01, 1'b0, 32'h15, 32'h0, 1, 32'h0, 1'b1);
        xact("rsvd_sz", 1'b0, 2'b11, 1'b0, 32'h14, 32'h0, 1, 32'h0, 1'b1);

        // T5 reset during MERGE of a byte store
        send(1'b1, 2'b00, 1'b0, 32'h14, 32'h77);
        chk("t5_merge_memwrite", {31'd0, bus.mem_memWrite}, 32'd0);
        chk("t5_merge_ready", {31'd0, bus.req_ready}, 32'd0);
        #2 reset_n = 1'b0;
        #1;
        chk("t5_rst_memwrite", {31'd0, bus.mem_memWrite}, 32'd0);
        for (int i = 0; i < 2; i++) begin
            step();
            chk("t5_hold_memwrite", {31'd0, bus.mem_memWrite}, 32'd0);
        end
        #3 reset_n = 1'b1;
        step();
        step();
        chk("t5_mem", mem[5], 32'h1234AABB);
        chk("t5_ready", {31'd0, bus.req_ready}, 32'd1);
        chk("t5_resp_valid", {31'd0, bus.resp_valid}, 32'd0);

        // T6 back-pressure on the response
        bus.resp_ready = 1'b0;
        send(1'b0, 2'b10, 1'b0, 32'h14, 32'h0);
        wait_resp();
        chk("t6_lat", 32'(lat), 32'd2);
        bus.req_store    = 1'b0;
        bus.req_size     = 2'b00;
        bus.req_signed   = 1'b0;
        bus.req_endereco = 32'h14;
        bus.req_valid    = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("t6_hold_valid", {31'd0, bus.resp_valid}, 32'd1);
            chk("t6_hold_dado", bus.resp_dado, 32'h1234AABB);
            chk("t6_hold_ready", {31'd0, bus.req_ready}, 32'd0);
            step();
        end
        bus.resp_ready = 1'b1;
        chk("t6_rel_ready", {31'd0, bus.req_ready}, 32'd0);
        step();
        chk("t6_idle_ready", {31'd0, bus.req_ready}, 32'd1);
        chk("t6_idle_valid", {31'd0, bus.resp_valid}, 32'd0);
        step();
        bus.req_valid = 1'b0;
        wait_resp();
        chk("t6_next_lat", 32'(lat), 32'd2);
        chk("t6_next_dado", bus.resp_dado, 32'h000000BB);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
